input_buffer: RTL and testbench
===============================

// Module: input_buffer
// PURPOSE
//  Load-side IO block; the read counterpart of the store-side output buffer.
//  Samples asynchronous board inputs (switches, push-buttons), synchronises and debounces them.
//  Returns LSU load data for IO addresses, formatted per RV32I funct3.
//  Sits beside the output buffer on the IO page, muxed into the LSU load-data path.
// PARAMETERS
//  NUM_SW          32  number of switch inputs (1..32), zero-extended into the SW word
//  NUM_BTN         4   number of push-buttons (1..32)
//  DEBOUNCE_CYCLES 4   consecutive stable cycles needed to accept a button change (>=1)
//  BTN_ACTIVE_LOW  1   1: pin low = pressed (inverted after sync); 0: pin high = pressed
// PORTS
//  i_clk        in   1        system clock
//  i_reset      in   1        asynchronous, active-high reset
//  i_io_sw      in   NUM_SW   raw switch pins, asynchronous
//  i_io_btn     in   NUM_BTN  raw button pins, asynchronous
//  i_io_addr    in   32       load byte address
//  i_funct3     in   3        load type
//  i_io_rden    in   1        load strobe, one cycle per load
//  o_ld_data    out  32       formatted load data, registered
//  o_ld_valid   out  1        o_ld_data valid; high the cycle after i_io_rden
// BEHAVIOUR
//  Reset (async, i_reset=1):
//   - o_ld_data=0, o_ld_valid=0.
//   - Sync flops, debounced levels, debounce counters and edge register all 0.
//  Synchronisation:
//   - 2-flop synchroniser on every SW and BTN bit.
//   - Buttons are inverted after sync when BTN_ACTIVE_LOW=1.
//  Debounce (per button):
//   - If sync == deb, cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync, cnt <= 0.
//   - Else cnt++.
//   - Pin change reaches deb after 2 + DEBOUNCE_CYCLES cycles. Shorter glitches are discarded.
//  Edge register (sticky, per button):
//   - Bit set on a deb 0->1 transition.
//   - Whole register cleared by any i_io_rden read of the EDGE page.
//   - Same-cycle set and clear: the set wins for that bit. The read returns the pre-update value.
//  Address map (decode on i_io_addr[31:12]):
//   - 0x1001_0 SW    : sync switches, zero-extended.
//   - 0x1001_1 BTN   : deb levels, zero-extended.
//   - 0x1001_2 EDGE  : sticky press flags, zero-extended.
//   - Any other page : word = 0.
//  Load formatting (off = i_io_addr[1:0]; byte/half selected from the 32-bit word):
//   - 000 LB  : byte[off], sign-extended.
//   - 001 LH  : half[off[1]], sign-extended; off[0] ignored.
//   - 010 LW  : full word.
//   - 100 LBU : byte[off], zero-extended.
//   - 101 LHU : half[off[1]], zero-extended.
//   - Other funct3 values : 0.
//  Latency and holding:
//   - One cycle: o_ld_data and o_ld_valid register on the edge after i_io_rden=1.
//   - With i_io_rden=0, o_ld_valid=0 next cycle and o_ld_data holds its last value.
//   - Back-to-back reads supported, one result per cycle.
//  Reset mid-operation: in-progress debounce is discarded and pending edges are lost.
// STRUCTURE
//  Package io_map_pkg:
//   - Page constants IO_PAGE_SW, IO_PAGE_BTN, IO_PAGE_EDGE; output pages 0x1000_0..4 live here too.
//   - Typedef ld_funct3_e: LB, LH, LW, LBU, LHU.
//  Sub-module io_debounce (sync + counter + deb level, 1 bit), instantiated NUM_BTN times via generate.
//  Switches use the sync stage only, no debounce.
// TESTING
//  1 Assert i_reset mid-debounce with btn held -> o_ld_data=0, o_ld_valid=0; after release, BTN and EDGE read 0.
//  2 SW=0x8000_00F0:
//     - LB  @0x1001_0000 -> 0xFFFF_FFF0.
//     - LBU @0x1001_0003 -> 0x0000_0080.
//     - LH  @0x1001_0002 -> 0xFFFF_8000.
//     - All with o_ld_valid 1 cycle after rden.
//  3 DEBOUNCE_CYCLES=4, btn0 pressed for 3 cycles -> BTN LW reads 0x0. Held 8 cycles -> reads 0x1 from cycle 6.
//  4 Press/release btn1 -> EDGE LW @0x1001_2000 = 0x2; immediate second read = 0x0.
//  5 btn0 edge in same cycle as EDGE read clearing 0x2 -> that read = 0x2, next read = 0x1.
//  6 LW @0x1000_3000 -> 0x0; funct3=011 @0x1001_0000 -> 0x0; rden idle -> o_ld_valid=0, data held.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: IO page map and RV32I load formatting shared by the IO blocks.
//   - Output-buffer pages 0x1000_0..0x1000_4 and input-buffer pages
//     0x1001_0 (SW), 0x1001_1 (BTN), 0x1001_2 (EDGE), compared with addr[31:12].
//   - ld_funct3_e: the RV32I load encodings.
//   - ld_format(): selects a byte or half of a 32-bit word and extends it.
package io_map_pkg;

  localparam logic [19:0] IO_PAGE_OUT0 = 20'h10000;
  localparam logic [19:0] IO_PAGE_OUT1 = 20'h10001;
  localparam logic [19:0] IO_PAGE_OUT2 = 20'h10002;
  localparam logic [19:0] IO_PAGE_OUT3 = 20'h10003;
  localparam logic [19:0] IO_PAGE_OUT4 = 20'h10004;

  localparam logic [19:0] IO_PAGE_SW   = 20'h10010;
  localparam logic [19:0] IO_PAGE_BTN  = 20'h10011;
  localparam logic [19:0] IO_PAGE_EDGE = 20'h10012;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_funct3_e;

  // Byte lane off, half lane off[1]; unsupported encodings read as zero.
  function automatic logic [31:0] ld_format(input logic [31:0] word,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  off);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] res;
    sel_b = word[{off, 3'b000} +: 8];
    if (off[1]) begin
      sel_h = word[31:16];
    end else begin
      sel_h = word[15:0];
    end
    case (funct3)
      LD_LB:   res = {{24{sel_b[7]}}, sel_b};
      LD_LH:   res = {{16{sel_h[15]}}, sel_h};
      LD_LW:   res = word;
      LD_LBU:  res = {24'd0, sel_b};
      LD_LHU:  res = {16'd0, sel_h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one button bit - 2-flop synchroniser, optional inversion,
// and a stability counter that accepts a new level only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the held level.
//   i_clk, i_reset : clock, async active-high reset
//   i_pin          : raw asynchronous pin
//   o_deb          : debounced level (1 = pressed)
//   o_rise         : one-cycle pulse in the cycle before o_deb goes 0->1
module io_debounce
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_deb,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_s;
  logic             deb_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;

  assign level_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

  // Debounce next-state: any return to the held level restarts the count.
  always_comb begin
    deb_nxt_s = deb_r;
    cnt_nxt_s = cnt_r;
    accept_s  = 1'b0;
    if (level_s == deb_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      deb_nxt_s = level_s;
      cnt_nxt_s = {CNT_W{1'b0}};
      accept_s  = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Synchroniser, debounced level and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= i_pin;
      sync2_r <= sync1_r;
      deb_r   <= deb_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign o_deb  = deb_r;
  assign o_rise = accept_s & level_s;

endmodule

// File: rtl/input_buffer.sv
// input_buffer: load-side IO block. Synchronises switches, debounces
// buttons, keeps sticky press flags and returns formatted load data.
//   i_clk, i_reset       : clock, async active-high reset
//   i_io_sw, i_io_btn    : raw asynchronous board pins
//   i_io_addr, i_funct3  : load address and RV32I load type
//   i_io_rden            : one-cycle load strobe
//   o_ld_data/o_ld_valid : registered result, valid the cycle after i_io_rden
module input_buffer
  import io_map_pkg::*;
#(
  parameter int NUM_SW          = 32,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SW-1:0]  i_io_sw,
  input  logic [NUM_BTN-1:0] i_io_btn,
  input  logic [31:0]        i_io_addr,
  input  logic [2:0]         i_funct3,
  input  logic               i_io_rden,
  output logic [31:0]        o_ld_data,
  output logic               o_ld_valid
);

  logic [NUM_SW-1:0]  sw_sync1_r;
  logic [NUM_SW-1:0]  sw_sync2_r;
  logic [NUM_BTN-1:0] btn_deb_s;
  logic [NUM_BTN-1:0] btn_rise_s;
  logic [NUM_BTN-1:0] edge_r;
  logic [NUM_BTN-1:0] edge_nxt_s;
  logic               edge_clr_s;
  logic [19:0]        page_s;
  logic [31:0]        word_s;
  logic               unused_addr_s;

  assign page_s        = i_io_addr[31:12];
  assign unused_addr_s = &{1'b0, i_io_addr[11:2]};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_deb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_pin   (i_io_btn[g]),
      .o_deb   (btn_deb_s[g]),
      .o_rise  (btn_rise_s[g])
    );
  end

  // Switch synchroniser; switches are level inputs and skip debounce.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_sync1_r <= {NUM_SW{1'b0}};
      sw_sync2_r <= {NUM_SW{1'b0}};
    end else begin
      sw_sync1_r <= i_io_sw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Page decode into the 32-bit word to be formatted.
  always_comb begin
    word_s = 32'd0;
    case (page_s)
      IO_PAGE_SW:   word_s = 32'(sw_sync2_r);
      IO_PAGE_BTN:  word_s = 32'(btn_deb_s);
      IO_PAGE_EDGE: word_s = 32'(edge_r);
      default:      word_s = 32'd0;
    endcase
  end

  // Sticky edges: a read of the EDGE page clears, a new press in the same
  // cycle is OR-ed in afterwards so it survives the clear.
  always_comb begin
    edge_clr_s = i_io_rden & (page_s == IO_PAGE_EDGE);
    if (edge_clr_s) begin
      edge_nxt_s = btn_rise_s;
    end else begin
      edge_nxt_s = edge_r | btn_rise_s;
    end
  end

  // Edge flag register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      edge_r <= {NUM_BTN{1'b0}};
    end else begin
      edge_r <= edge_nxt_s;
    end
  end

  // Load result register; data holds between reads.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ld_data  <= 32'd0;
      o_ld_valid <= 1'b0;
    end else if (i_io_rden) begin
      o_ld_data  <= ld_format(word_s, i_funct3, i_io_addr[1:0]);
      o_ld_valid <= 1'b1;
    end else begin
      o_ld_data  <= o_ld_data;
      o_ld_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer with default parameters
// (32 switches, 4 active-low buttons, DEBOUNCE_CYCLES = 4).
module tb_input_buffer;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] i_io_addr;
  logic [2:0]  i_funct3;
  logic        i_io_rden;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;

  int checks;
  int failures;

  localparam logic [31:0] A_SW   = 32'h1001_0000;
  localparam logic [31:0] A_BTN  = 32'h1001_1000;
  localparam logic [31:0] A_EDGE = 32'h1001_2000;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  input_buffer dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_io_sw    (i_io_sw),
    .i_io_btn   (i_io_btn),
    .i_io_addr  (i_io_addr),
    .i_funct3   (i_funct3),
    .i_io_rden  (i_io_rden),
    .o_ld_data  (o_ld_data),
    .o_ld_valid (o_ld_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // One load: strobe for one cycle, check the result one cycle later.
  task automatic rd(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] exp);
    @(negedge i_clk);
    i_io_addr = addr;
    i_funct3  = f3;
    i_io_rden = 1'b1;
    @(negedge i_clk);
    i_io_rden = 1'b0;
    chk({nm, "_valid"}, {31'd0, o_ld_valid}, 32'd1);
    chk(nm, o_ld_data, exp);
  endtask

  // Hold button b pressed (pin low) for n cycles, then release and settle.
  task automatic press(input int b, input int n);
    @(negedge i_clk);
    i_io_btn[b] = 1'b0;
    repeat (n) @(negedge i_clk);
    i_io_btn[b] = 1'b1;
    repeat (10) @(negedge i_clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    i_reset   = 1'b1;
    i_io_sw   = 32'h1234_5678;
    i_io_btn  = 4'hF;
    i_io_addr = 32'd0;
    i_funct3  = 3'b010;
    i_io_rden = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_data", o_ld_data, 32'd0);
    chk("rst_valid", {31'd0, o_ld_valid}, 32'd0);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    rd("sw_pre_rst", A_SW, 3'b010, 32'h1234_5678);

    // Reset in the middle of a debounce with the button held
    @(negedge i_clk);
    i_io_btn[0] = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("midrst_data", o_ld_data, 32'd0);
    chk("midrst_valid", {31'd0, o_ld_valid}, 32'd0);
    i_io_btn[0] = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    rd("midrst_btn", A_BTN, 3'b010, 32'd0);
    rd("midrst_edge", A_EDGE, 3'b010, 32'd0);

    // Load formatting table on SW = 0x8000_00F0
    i_io_sw = 32'h8000_00F0;
    repeat (3) @(negedge i_clk);
    vecs[0]  = '{"lb_b0",      A_SW,            3'b000, 32'hFFFF_FFF0};
    vecs[1]  = '{"lbu_b3",     A_SW + 32'd3,    3'b100, 32'h0000_0080};
    vecs[2]  = '{"lh_h1",      A_SW + 32'd2,    3'b001, 32'hFFFF_8000};
    vecs[3]  = '{"lh_h1_odd",  A_SW + 32'd3,    3'b001, 32'hFFFF_8000};
    vecs[4]  = '{"lhu_h0",     A_SW,            3'b101, 32'h0000_00F0};
    vecs[5]  = '{"lbu_b1",     A_SW + 32'd1,    3'b100, 32'h0000_0000};
    vecs[6]  = '{"lb_b3",      A_SW + 32'd3,    3'b000, 32'hFFFF_FF80};
    vecs[7]  = '{"lw_sw",      A_SW,            3'b010, 32'h8000_00F0};
    vecs[8]  = '{"lw_outpage", 32'h1000_3000,   3'b010, 32'h0000_0000};
    vecs[9]  = '{"f3_011",     A_SW,            3'b011, 32'h0000_0000};
    vecs[10] = '{"f3_111",     A_SW,            3'b111, 32'h0000_0000};
    for (int i = 0; i < 11; i++) begin
      rd(vecs[i].nm, vecs[i].addr, vecs[i].f3, vecs[i].exp);
    end

    // Idle: valid drops, data holds
    rd("lw_before_idle", A_SW, 3'b010, 32'h8000_00F0);
    @(negedge i_clk);
    chk("idle_valid", {31'd0, o_ld_valid}, 32'd0);
    chk("idle_hold", o_ld_data, 32'h8000_00F0);

    // Short glitch (3 cycles) is discarded
    press(0, 3);
    rd("glitch_btn", A_BTN, 3'b010, 32'd0);
    rd("glitch_edge", A_EDGE, 3'b010, 32'd0);

    // Held 8 cycles: level accepted on the 6th edge after the pin change
    @(negedge i_clk);
    i_io_btn[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clk);
      if (c == 6) chk("btn_at_c5", o_ld_data, 32'd0);
      if (c == 7) chk("btn_at_c6", o_ld_data, 32'd1);
      i_io_addr = A_BTN;
      i_funct3  = 3'b010;
      i_io_rden = (c == 5 || c == 6);
    end
    i_io_btn[0] = 1'b1;
    repeat (10) @(negedge i_clk);
    rd("edge_btn0", A_EDGE, 3'b010, 32'h1);

    // Press/release btn1; read clears the flags
    press(1, 8);
    rd("edge_btn1", A_EDGE, 3'b010, 32'h2);
    rd("edge_cleared", A_EDGE, 3'b010, 32'h0);

    // Set and clear in the same cycle: the new btn0 flag survives
    press(1, 8);
    @(negedge i_clk);
    i_io_btn[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge i_clk);
      if (c == 6) begin
        chk("edge_race_valid", {31'd0, o_ld_valid}, 32'd1);
        chk("edge_race_read", o_ld_data, 32'h2);
      end
      i_io_addr = A_EDGE;
      i_funct3  = 3'b010;
      i_io_rden = (c == 5);
    end
    rd("edge_race_next", A_EDGE, 3'b010, 32'h1);
    rd("btn_level_held", A_BTN, 3'b010, 32'h1);
    i_io_btn[0] = 1'b1;
    repeat (10) @(negedge i_clk);
    rd("btn_level_rel", A_BTN, 3'b010, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
